// File: rtl/shift_issue_if.sv
// -----------------------------------------------------------------------------
// shift_issue_if
// Handshake bundle for the shift issue/retire stage.
//   Issue side    : in_valid, in_ready, instr[15:0], operand[15:0]
//   Retire side   : out_valid, out_ready, result[15:0], szcv[3:0], rd[3:0],
//                   illegal
// Modports:
//   master - the upstream/writeback side (drives instructions, accepts results)
//   slave  - the shift_issue stage itself
// -----------------------------------------------------------------------------
interface shift_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [15:0] operand;

    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  szcv;
    logic [3:0]  rd;
    logic        illegal;

    modport master (
        output in_valid, instr, operand, out_ready,
        input  in_ready, out_valid, result, szcv, rd, illegal
    );

    modport slave (
        input  in_valid, instr, operand, out_ready,
        output in_ready, out_valid, result, szcv, rd, illegal
    );
endinterface

// File: rtl/shift_issue.sv
// -----------------------------------------------------------------------------
// shift_issue
// Issue/retire stage around the combinational 16-bit execute-path shifter.
// An instruction is accepted in IDLE, the shifter is driven from registers for
// one EXEC cycle, and the result plus SZCV flags are captured and held in HOLD
// until writeback takes them. Shift-by-zero is resolved here because the
// shifter's carry is undefined at d=0.
//
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   bus (slave)       - issue handshake (in_valid/in_ready/instr/operand) and
//                       retire handshake (out_valid/out_ready/result/szcv/rd/
//                       illegal)
//   sft_ctl[3:0]      - shifter control {2'b10, op}; zero outside EXEC
//   sft_d[3:0]        - shifter amount; zero outside EXEC
//   sft_in[15:0]      - shifter operand; zero outside EXEC
//   sft_out[15:0]     - shifter result
//   sft_szcv[3:0]     - shifter flags {S,Z,C,V}
//   flags_q[3:0]      - architectural flag register
//
// Build option:
//   SHIFT_FLAG_REG_EN - when defined, flags_q loads szcv on every legal retire;
//                       when undefined, flags_q is tied to zero.
// -----------------------------------------------------------------------------
module shift_issue (
    input  logic               clk,
    input  logic               rst_n,
    shift_issue_if.slave       bus,
    output logic [3:0]         sft_ctl,
    output logic [3:0]         sft_d,
    output logic [15:0]        sft_in,
    input  logic [15:0]        sft_out,
    input  logic [3:0]         sft_szcv,
    output logic [3:0]         flags_q
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t      state;
    logic        out_valid_q;
    logic [15:0] result_q;
    logic [3:0]  szcv_q;
    logic [3:0]  rd_q;
    logic        illegal_q;

    // Instruction bits [7:4] carry no meaning here, and V from the shifter is
    // replaced by a constant 0.
    logic unused_bits;
    assign unused_bits = ^{bus.instr[7:4], sft_szcv[0]};

    // rst_n is folded in so the stage never advertises ready while held in
    // reset, independent of the registered state.
    assign bus.in_ready  = rst_n && (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.szcv      = szcv_q;
    assign bus.rd        = rd_q;
    assign bus.illegal   = illegal_q;

    // The shifter inputs double as the operand/op/d latches: they are loaded
    // on accept, used for capture in EXEC, and cleared on leaving EXEC.
    // NOTE: sequential state is always assigned with <= so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= 16'h0000;
            szcv_q      <= 4'b0000;
            rd_q        <= 4'h0;
            illegal_q   <= 1'b0;
            sft_ctl     <= 4'h0;
            sft_d       <= 4'h0;
            sft_in      <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sft_ctl   <= {2'b10, bus.instr[13:12]};
                        sft_d     <= bus.instr[3:0];
                        sft_in    <= bus.operand;
                        rd_q      <= bus.instr[11:8];
                        illegal_q <= (bus.instr[15:14] != 2'b10);
                        state     <= EXEC;
                    end
                end

                EXEC: begin
                    if (illegal_q) begin
                        result_q <= sft_in;
                        szcv_q   <= 4'b0000;
                    end else if (sft_d == 4'h0) begin
                        // Bypass: the shifter's carry is undefined at d=0.
                        result_q <= sft_in;
                        szcv_q   <= {sft_in[15], (sft_in == 16'h0000), 2'b00};
                    end else begin
                        result_q <= sft_out;
                        szcv_q   <= {sft_szcv[3:1], 1'b0};
                    end
                    sft_ctl     <= 4'h0;
                    sft_d       <= 4'h0;
                    sft_in      <= 16'h0000;
                    out_valid_q <= 1'b1;
                    state       <= HOLD;
                end

                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef SHIFT_FLAG_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (out_valid_q && bus.out_ready && !illegal_q) begin
            flags_q <= szcv_q;
        end
    end
`else
    assign flags_q = 4'b0000;
`endif

endmodule

// File: tb/tb_shift_issue.sv
// -----------------------------------------------------------------------------
// tb_shift_issue
// Directed bench for shift_issue. A behavioural shifter drives sft_out/sft_szcv
// (returning junk at d=0 so any leak past the bypass is visible). Expected
// results are hand-computed constants pushed into a scoreboard on accept; a
// monitor pops and compares on every retire handshake.
// -----------------------------------------------------------------------------
module tb_shift_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  sft_ctl;
    logic [3:0]  sft_d;
    logic [15:0] sft_in;
    logic [15:0] sft_out;
    logic [3:0]  sft_szcv;
    logic [3:0]  flags_q;

    shift_issue_if bus ();

    shift_issue dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .sft_ctl  (sft_ctl),
        .sft_d    (sft_d),
        .sft_in   (sft_in),
        .sft_out  (sft_out),
        .sft_szcv (sft_szcv),
        .flags_q  (flags_q)
    );

    always #5 clk = ~clk;

    // Behavioural shifter. C: SLL -> last bit out of the top, SRL/SRA -> last
    // bit out of the bottom, ROL -> bit rotated into bit 0.
    always_comb begin
        sft_out  = 16'hDEAD;
        sft_szcv = 4'b1111;
        if (sft_d != 4'h0) begin
            case (sft_ctl[1:0])
                2'b00: begin
                    sft_out     = sft_in << sft_d;
                    sft_szcv[1] = sft_in[16 - int'(sft_d)];
                end
                2'b01: begin
                    sft_out     = (sft_in << sft_d) | (sft_in >> (16 - int'(sft_d)));
                    sft_szcv[1] = sft_out[0];
                end
                2'b10: begin
                    sft_out     = sft_in >> sft_d;
                    sft_szcv[1] = sft_in[int'(sft_d) - 1];
                end
                default: begin
                    sft_out     = 16'($signed(sft_in) >>> sft_d);
                    sft_szcv[1] = sft_in[int'(sft_d) - 1];
                end
            endcase
            sft_szcv[3] = sft_out[15];
            sft_szcv[2] = (sft_out == 16'h0000);
            sft_szcv[0] = 1'b0;
        end
    end

    typedef struct packed {
        logic [15:0] result;
        logic [3:0]  szcv;
        logic [3:0]  rd;
        logic        illegal;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_retired = 0;
    logic [3:0] exp_flags = 4'b0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: the handshake is stable at the falling edge and
    // completes on the following rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_retired++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_retire", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_result",  32'(bus.result),  32'(e.result));
                check("sb_szcv",    32'(bus.szcv),    32'(e.szcv));
                check("sb_rd",      32'(bus.rd),      32'(e.rd));
                check("sb_illegal", 32'(bus.illegal), 32'(e.illegal));
            end
        end
    end

    task automatic run_op(input logic [15:0] ins, input logic [15:0] opd,
                          input logic [15:0] er, input logic [3:0] es, input int stall);
        logic ill;
        ill = (ins[15:14] != 2'b10);
        @(posedge clk); #1;
        bus.instr    = ins;
        bus.operand  = opd;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        exp_q.push_back('{er, es, ins[11:8], ill});
        @(posedge clk); #1;                       // accept edge
        bus.in_valid = 1'b0;
        bus.instr    = 16'h0000;
        bus.operand  = 16'h0000;
        @(negedge clk);                           // EXEC
        check("exec_out_valid", 32'(bus.out_valid), 32'd0);
        check("exec_in_ready",  32'(bus.in_ready),  32'd0);
        check("exec_sft_ctl",   32'(sft_ctl), 32'({2'b10, ins[13:12]}));
        check("exec_sft_d",     32'(sft_d),   32'(ins[3:0]));
        check("exec_sft_in",    32'(sft_in),  32'(opd));
        @(negedge clk);                           // HOLD, two edges after accept
        check("hold_out_valid", 32'(bus.out_valid), 32'd1);
        check("hold_sft_zero",  32'({sft_ctl, sft_d, sft_in}), 32'd0);
        for (int i = 0; i < stall; i++) begin
            check("stall_in_ready",  32'(bus.in_ready),  32'd0);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_result",    32'(bus.result),    32'(er));
            check("stall_szcv",      32'(bus.szcv),      32'(es));
            check("stall_rd",        32'(bus.rd),        32'(ins[11:8]));
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;                       // retire edge
        bus.out_ready = 1'b0;
`ifdef SHIFT_FLAG_REG_EN
        if (!ill) exp_flags = es;
`endif
        @(negedge clk);
        check("retire_in_ready",  32'(bus.in_ready),  32'd1);
        check("retire_out_valid", 32'(bus.out_valid), 32'd0);
        check("flags_q",          32'(flags_q),       32'(exp_flags));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.instr     = 16'h0000;
        bus.operand   = 16'h0000;
        bus.out_ready = 1'b0;
        #2;
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_outputs",   32'({bus.result, bus.szcv, bus.rd, bus.illegal}), 32'd0);
        check("rst_flags_q",   32'(flags_q), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // instr,   operand,  result,  szcv,   stall
        run_op(16'h8004, 16'hF001, 16'h0010, 4'b0010, 0);  // SLL d=4, C=in[12]
        run_op(16'hB004, 16'h8000, 16'hF800, 4'b1000, 0);  // SRA d=4
        run_op(16'h9008, 16'h1234, 16'h3412, 4'b0000, 0);  // ROL d=8
        run_op(16'hA000, 16'h0000, 16'h0000, 4'b0100, 0);  // SRL d=0 bypass, zero
        run_op(16'h8300, 16'h8001, 16'h8001, 4'b1000, 0);  // SLL d=0 bypass, negative
        run_op(16'h0123, 16'hBEEF, 16'hBEEF, 4'b0000, 0);  // illegal class
        run_op(16'hA501, 16'h0003, 16'h0001, 4'b0010, 5);  // SRL d=1, backpressure

        // Reset while in EXEC: the in-flight op must never retire.
        @(posedge clk); #1;
        bus.instr    = 16'h8704;
        bus.operand  = 16'h00FF;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_exec_sft_in", 32'(sft_in), 32'h00FF);
        rst_n = 1'b0;
        exp_flags = 4'b0000;
        #1;
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_outputs",   32'({bus.result, bus.szcv, bus.rd, bus.illegal}), 32'd0);
        check("mid_rst_sft",       32'({sft_ctl, sft_d, sft_in}), 32'd0);
        check("mid_rst_flags_q",   32'(flags_q), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("in_rst_out_valid", 32'(bus.out_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

        run_op(16'h8201, 16'h8000, 16'h0000, 4'b0110, 0);  // SLL d=1, C=in[15], Z

        repeat (2) @(negedge clk);
        check("retired_count",   32'(n_retired),    32'd8);
        check("sb_left_pending", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
